seg7_scan_decoder: RTL

- Recovers digit values from a multiplexed 7-segment display bus (anodes plus shared cathodes). This is the inverse of the BCD-to-segment encoder.
- Sits between the display driver outputs and the self-check/readback logic. It lets the alarm clock, or a bench monitor, confirm what the panel actually shows.
- Each digit is captured only after its anode/cathode pair has been stable for a programmable number of cycles. A one-cycle strobe marks each completed scan frame.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_pattern_decode.sv | 29 ++
 rtl/seg7_scan_decoder.sv | 106 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment readback path: segment patterns (active-low,
// bit6=a .. bit0=g), recovered digit codes and scan FSM state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_DASH    = 4'hA;
  localparam logic [3:0] CODE_BLANK   = 4'hB;
  localparam logic [3:0] CODE_INVALID = 4'hF;

  typedef logic [1:0] state_t;
  localparam state_t ST_WAIT  = 2'd0;
  localparam state_t ST_COUNT = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the BCD-to-segment encoder; unknown patterns map to
// CODE_INVALID so a lit-but-wrong segment is visible to readback logic.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code
);

  always_comb begin
    code = CODE_INVALID;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_DASH:  code = CODE_DASH;
      SEG_BLANK: code = CODE_BLANK;
      default:   code = CODE_INVALID;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers per-digit codes from a multiplexed 7-segment bus; a digit is committed
// once its anode/cathode pair has been sampled STABLE_CYCLES times in a row.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int N_DIGITS      = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int CW            = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_DIGITS-1:0]   an,
  input  logic [6:0]            seg,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic                  frame_done,
  output logic                  anode_err
);

  localparam int IW = $clog2(N_DIGITS);

  logic [N_DIGITS-1:0]   an_q;
  logic [6:0]            seg_q;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [N_DIGITS-1:0]   seen;
  logic [4*N_DIGITS-1:0] digits_q;
  logic [N_DIGITS-1:0]   valid_q;
  logic                  frame_q;
  logic                  err_q;

  logic [3:0]            code;
  logic                  change;
  logic                  commit;
  logic [N_DIGITS-1:0]   sel;
  logic                  sel_one;
  logic                  sel_multi;
  logic [IW-1:0]         sel_idx;

  seg7_pattern_decode u_decode (
    .seg  (seg),
    .code (code)
  );

  assign change = (an != an_q) || (seg != seg_q);
  // The commit edge is the one that takes the STABLE_CYCLES-th identical sample.
  assign commit = !change && (state == ST_COUNT) && (cnt == CW'(STABLE_CYCLES - 1));

  assign sel       = ~an;
  assign sel_one   = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  assign sel_multi = (sel != '0) && !sel_one;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (sel[i]) sel_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q     <= '1;
      seg_q    <= '1;
      state    <= ST_WAIT;
      cnt      <= '0;
      seen     <= '0;
      digits_q <= {N_DIGITS{CODE_BLANK}};
      valid_q  <= '0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      an_q    <= an;
      seg_q   <= seg;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
      if (change) begin
        state <= ST_COUNT;
        cnt   <= CW'(1);
      end else if (commit) begin
        state <= ST_HOLD;
        cnt   <= CW'(STABLE_CYCLES);
        if (sel_multi) begin
          err_q <= 1'b1;
        end else if (sel_one) begin
          digits_q[4*sel_idx +: 4] <= code;
          valid_q[sel_idx]         <= 1'b1;
          // The digit that completes a frame does not count toward the next one.
          if ((seen | sel) == '1) begin
            frame_q <= 1'b1;
            seen    <= '0;
          end else begin
            seen[sel_idx] <= 1'b1;
          end
        end
      end else if (state == ST_COUNT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_q;
  assign anode_err   = err_q;

endmodule
